intr_ctrl: RTL and testbench
============================

# intr_ctrl

Interrupt controller feeding the CPU's interrupt vector lookup. Captures rising edges on eight external request lines into a pending register, masks them, selects the highest-priority eligible request (bit 0 highest) and presents it one-hot on `intr_selec` for vector decode. Handshakes with the CPU control unit: raises `intr_out`, clears the served pending bit on `intr_ack`, and blocks further requests until `intr_ret`.

## Interface
- `NINTR`, 8, number of request lines; must equal the vector decoder's select width.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `intr_req`  in  NINTR  external request lines, level; an event is a 0→1 transition.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_in`  in  NINTR  mask value; 1 = line enabled.
- `intr_ack`  in  1  CPU accepts the interrupt (vector fetched, PC saved), one-cycle pulse.
- `intr_ret`  in  1  CPU executes return-from-interrupt, one-cycle pulse.
- `intr_out`  out  1  interrupt request to the CPU.
- `intr_selec`  out  NINTR  one-hot selected line, to the vector decoder.
- `in_service`  out  1  handler running.
- `pend_out`  out  NINTR  pending register, for status reads.

## Operation
- Reset: pending = 0, mask = 0, edge history = 0, state IDLE; `intr_out`=0, `intr_selec`=0, `in_service`=0, `pend_out`=0.
- Edge capture: per bit, pending set on a detected rising edge; held until cleared by ack. Repeated edges while pending are absorbed (no counting).
- Mask: `mask_we` loads `mask_in` at the clock edge. Eligible = pending & mask. Masked lines still accumulate pending.
- Priority: lowest-index eligible bit wins; result one-hot.
- FSM, three states:
  - IDLE: `intr_selec`=0. If eligible ≠ 0 → REQ, register one-hot winner into `intr_selec`.
  - REQ: `intr_out`=1, `intr_selec` frozen. On `intr_ack` → SERVICE, clear pending bit of `intr_selec`.
  - SERVICE: `in_service`=1, `intr_selec` held. On `intr_ret` → IDLE.
- No nesting: new edges in REQ/SERVICE only set pending.
- Mask write in REQ does not withdraw the latched request; effective from next IDLE evaluation.
- Same-cycle set and ack-clear on the same bit: set wins (bit stays pending).
- `intr_ack` outside REQ and `intr_ret` outside SERVICE are ignored.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

## Timing
- Edge → pending: 1 clock edge without synchronizer; 3 with (see Configuration).
- Pending eligible in IDLE → REQ (`intr_out`, `intr_selec` valid) at the next clock edge.
- `intr_ack` sampled at edge k: state SERVICE and pending bit cleared after edge k.
- `intr_ret` at edge k: IDLE after k; a still-eligible request reaches REQ at edge k+1 (minimum one IDLE cycle).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `INTR_SYNC_EN` defined: two-flop synchronizer on every `intr_req` bit before edge detect; pending visible 3 edges after the line goes high.
- Not defined: `intr_req` treated as synchronous to `clk`; single history register, pending visible 1 edge after.
- Functional behaviour otherwise identical.

## Structure
- Package `intr_pkg`: `NINTR` constant, state encoding typedef (IDLE, REQ, SERVICE), lowest-bit-first one-hot priority function.
- Sub-module `intr_edge_det`: per-line optional synchronizer plus rising-edge detector, outputs one-cycle edge pulses; instantiated once, NINTR wide.

## Test plan
- Reset: drive `intr_req`=8'hFF, release reset, mask 0 → `pend_out`=8'hFF, `intr_out` stays 0, `intr_selec`=0.
- Single request: mask 8'hFF, pulse bit 3 → REQ with `intr_selec`=8'b00001000; `intr_ack` → bit 3 cleared, `in_service`=1; `intr_ret` → IDLE.
- Priority: edges on bits 5 and 2 same cycle → `intr_selec`=8'b00000100; after ret, next REQ selects 8'b00100000.
- Masking: mask 8'hFE, edge bit 0 → no request; write mask 8'hFF → REQ with 8'b00000001 one edge later.
- Collision: new edge on bit 4 in the ack cycle for bit 4 → bit 4 remains pending, re-requested after `intr_ret`.
- Mid-operation reset in SERVICE → all outputs 0 asynchronously; no request until a fresh edge after mask rewrite.

Source files
------------

// File: rtl/intr_pkg.sv
// intr_pkg: shared constants, FSM state encoding and the priority picker
// used by the interrupt controller.
package intr_pkg;

  // Number of request lines; must match the vector decoder select width.
  localparam int NINTR = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intr_state_e;

  // One-hot of the lowest set bit (bit 0 has the highest priority).
  function automatic logic [NINTR-1:0] prio_onehot(input logic [NINTR-1:0] v);
    logic [NINTR-1:0] r;
    r = '0;
    for (int i = NINTR - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intr_edge_det.sv
// intr_edge_det: per-line rising-edge detector producing one-cycle pulses.
// Build option INTR_SYNC_EN: when defined, each line first passes through a
// two-flop synchronizer (lines asynchronous to clk); otherwise the lines are
// assumed synchronous and only a single history register is used.
module intr_edge_det
  import intr_pkg::*;
#(
  parameter int W = NINTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_req,
  output logic [W-1:0] o_edge
);

  logic [W-1:0] w_lvl;
  logic [W-1:0] r_hist;

`ifdef INTR_SYNC_EN
  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;

  // Two-flop synchronizer bringing the request lines into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_req;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lvl = r_sync2;
`else
  assign w_lvl = i_req;
`endif

  // Previous level of each line, used to spot 0->1 transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_lvl;
    end
  end

  assign o_edge = w_lvl & ~r_hist;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller in front of the CPU vector lookup.
// Captures request edges into a pending register, masks them, picks the
// lowest-index eligible line and runs an IDLE/REQ/SERVICE handshake with
// the CPU. All outputs come straight from flops.
// Build option INTR_SYNC_EN: adds a two-flop synchronizer on intr_req
// (see intr_edge_det).
module intr_ctrl
  import intr_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NINTR-1:0] intr_req,
  input  logic             mask_we,
  input  logic [NINTR-1:0] mask_in,
  input  logic             intr_ack,
  input  logic             intr_ret,
  output logic             intr_out,
  output logic [NINTR-1:0] intr_selec,
  output logic             in_service,
  output logic [NINTR-1:0] pend_out
);

  logic [NINTR-1:0] w_edge;
  logic [NINTR-1:0] w_elig;
  logic [NINTR-1:0] w_clr;
  logic [NINTR-1:0] w_selec_nxt;
  logic [NINTR-1:0] r_pend;
  logic [NINTR-1:0] r_mask;
  logic [NINTR-1:0] r_selec;
  logic             r_intr_out;
  logic             r_in_service;
  intr_state_e      r_state;
  intr_state_e      w_state_nxt;

  intr_edge_det #(
    .W (NINTR)
  ) u_edge_det (
    .clk    (clk),
    .reset  (reset),
    .i_req  (intr_req),
    .o_edge (w_edge)
  );

  // Masked lines keep accumulating pending; only eligibility is gated.
  assign w_elig = r_pend & r_mask;

  // Next-state and selection logic; the selection is frozen outside IDLE,
  // so a mask write during REQ never withdraws the latched request.
  always_comb begin
    w_state_nxt = r_state;
    w_selec_nxt = r_selec;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        w_selec_nxt = '0;
        if (|w_elig) begin
          w_state_nxt = ST_REQ;
          w_selec_nxt = prio_onehot(w_elig);
        end
      end
      ST_REQ: begin
        if (intr_ack) begin
          w_state_nxt = ST_SERVICE;
          w_clr       = r_selec;
        end
      end
      ST_SERVICE: begin
        if (intr_ret) begin
          w_state_nxt = ST_IDLE;
          w_selec_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_selec_nxt = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered handshake outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_selec      <= '0;
      r_intr_out   <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_selec      <= w_selec_nxt;
      r_intr_out   <= (w_state_nxt == ST_REQ);
      r_in_service <= (w_state_nxt == ST_SERVICE);
    end
  end

  // Pending register: a new edge beats a same-cycle ack clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_edge;
    end
  end

  // Mask register, loaded by the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
    end else if (mask_we) begin
      r_mask <= mask_in;
    end
  end

  assign intr_out   = r_intr_out;
  assign intr_selec = r_selec;
  assign in_service = r_in_service;
  assign pend_out   = r_pend;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl.
module tb_intr_ctrl;
  import intr_pkg::*;

`ifdef INTR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             reset;
  logic [NINTR-1:0] intr_req;
  logic             mask_we;
  logic [NINTR-1:0] mask_in;
  logic             intr_ack;
  logic             intr_ret;
  logic             intr_out;
  logic [NINTR-1:0] intr_selec;
  logic             in_service;
  logic [NINTR-1:0] pend_out;

  int n_checks;
  int n_fail;

  intr_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .intr_req   (intr_req),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .intr_ack   (intr_ack),
    .intr_ret   (intr_ret),
    .intr_out   (intr_out),
    .intr_selec (intr_selec),
    .in_service (in_service),
    .pend_out   (pend_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_mask(input logic [NINTR-1:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic pulse_ack();
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    intr_ret = 1'b1;
    tick();
    intr_ret = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic o, input logic [7:0] sel,
                            input logic svc, input logic [7:0] pnd);
    check({tag, ".out"}, {31'd0, intr_out}, {31'd0, o});
    check({tag, ".sel"}, {24'd0, intr_selec}, {24'd0, sel});
    check({tag, ".svc"}, {31'd0, in_service}, {31'd0, svc});
    check({tag, ".pend"}, {24'd0, pend_out}, {24'd0, pnd});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    intr_req = 8'hFF;
    mask_we  = 1'b0;
    mask_in  = '0;
    intr_ack = 1'b0;
    intr_ret = 1'b0;

    // Reset values, then all lines already high at release
    ticks(2);
    check_outs("rst", 1'b0, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    ticks(LAT);
    check_outs("rst_pend", 1'b0, 8'h00, 1'b0, 8'hFF);
    ticks(2);
    check("rst_noreq", {31'd0, intr_out}, 32'd0);

    // Single request on bit 3
    intr_req = 8'h00;
    do_reset();
    ticks(LAT);
    write_mask(8'hFF);
    intr_req = 8'h08;
    ticks(LAT);
    check_outs("s_pend", 1'b0, 8'h00, 1'b0, 8'h08);
    tick();
    check_outs("s_req", 1'b1, 8'h08, 1'b0, 8'h08);
    intr_req = 8'h00;
    tick();
    check_outs("s_hold", 1'b1, 8'h08, 1'b0, 8'h08);
    pulse_ack();
    check_outs("s_ack", 1'b0, 8'h08, 1'b1, 8'h00);
    pulse_ack();
    check_outs("s_ack_ign", 1'b0, 8'h08, 1'b1, 8'h00);
    pulse_ret();
    check_outs("s_ret", 1'b0, 8'h00, 1'b0, 8'h00);
    pulse_ret();
    check_outs("s_ret_ign", 1'b0, 8'h00, 1'b0, 8'h00);
    ticks(LAT);

    // Priority: bits 5 and 2 together
    intr_req = 8'h24;
    ticks(LAT);
    check("p_pend", {24'd0, pend_out}, 32'h24);
    tick();
    check_outs("p_req1", 1'b1, 8'h04, 1'b0, 8'h24);
    intr_req = 8'h00;
    pulse_ack();
    check_outs("p_ack1", 1'b0, 8'h04, 1'b1, 8'h20);
    pulse_ret();
    check_outs("p_idle", 1'b0, 8'h00, 1'b0, 8'h20);
    tick();
    check_outs("p_req2", 1'b1, 8'h20, 1'b0, 8'h20);
    pulse_ack();
    pulse_ret();
    check_outs("p_done", 1'b0, 8'h00, 1'b0, 8'h00);
    ticks(LAT);

    // Masking: bit 0 disabled, then enabled
    write_mask(8'hFE);
    intr_req = 8'h01;
    ticks(LAT);
    check("m_pend", {24'd0, pend_out}, 32'h01);
    ticks(2);
    check("m_blocked", {31'd0, intr_out}, 32'd0);
    write_mask(8'hFF);
    check("m_wr", {31'd0, intr_out}, 32'd0);
    tick();
    check_outs("m_req", 1'b1, 8'h01, 1'b0, 8'h01);
    intr_req = 8'h00;
    pulse_ack();
    pulse_ret();
    check_outs("m_done", 1'b0, 8'h00, 1'b0, 8'h00);
    ticks(LAT);

    // Collision: fresh edge on bit 4 lands in its own ack cycle
    intr_req = 8'h10;
    ticks(LAT);
    tick();
    check_outs("c_req", 1'b1, 8'h10, 1'b0, 8'h10);
    intr_req = 8'h00;
    ticks(LAT);
    intr_req = 8'h10;
    ticks(LAT - 1);
    pulse_ack();
    check_outs("c_ack", 1'b0, 8'h10, 1'b1, 8'h10);
    pulse_ret();
    check_outs("c_ret", 1'b0, 8'h00, 1'b0, 8'h10);
    tick();
    check_outs("c_rereq", 1'b1, 8'h10, 1'b0, 8'h10);
    pulse_ack();
    pulse_ret();
    intr_req = 8'h00;
    ticks(LAT);

    // Asynchronous reset while in SERVICE with another line pending
    intr_req = 8'h02;
    ticks(LAT);
    tick();
    check("r_req", {24'd0, intr_selec}, 32'h02);
    pulse_ack();
    intr_req = 8'h42;
    ticks(LAT);
    check_outs("r_svc", 1'b0, 8'h02, 1'b1, 8'h40);
    intr_req = 8'h00;
    #2;
    reset = 1'b0;
    #1;
    check_outs("r_async", 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    ticks(LAT + 2);
    write_mask(8'hFF);
    ticks(2);
    check_outs("r_quiet", 1'b0, 8'h00, 1'b0, 8'h00);
    intr_req = 8'h40;
    ticks(LAT);
    tick();
    check_outs("r_fresh", 1'b1, 8'h40, 1'b0, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
